irq_controller: RTL and testbench

- Memory-mapped interrupt controller peripheral on the SoC register bus.
- Latches rising edges from N_SRC external sources into a pending register, masks them with an enable register, and presents one level interrupt to the CPU.
- Arbitrates by fixed priority (lowest index wins) and sequences a claim/complete handshake with software.
- Register writes use the standard four-alias access scheme: MAIN/SET/CLR/INV, selected by address bits [3:2].

---
 rtl/irq_controller_if.sv | 28 ++
 rtl/irq_controller.sv | 134 +++++++++++++
 tb/tb_irq_controller.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Register bus bundle for the interrupt controller.
// The master issues one-cycle strobes and the slave acks one cycle later.
interface irq_controller_if;
  logic        bus_req;
  logic        bus_wr;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_wr,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_wr,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-latched, fixed-priority interrupt controller.
// Software claims and completes interrupts through the register bus.
module irq_controller #(
  parameter int N_SRC = 16,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  irq_controller_if.slave  bus,
  output logic             irq_out
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] sync1_q, sync2_q, edge_q;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] rise, masked, win_oh, wd;
  logic [ID_W-1:0]  cur_id_q, cur_id_d, win_id;
  logic [31:0]      rdata_q, rdata_d, status;
  logic             ack_q, irq_q;
  logic             rd, wr, claim_rd, claim_wr;
  logic [1:0]       sel, acc;
  logic             unused_bits;

  assign rd       = bus.bus_req & ~bus.bus_wr;
  assign wr       = bus.bus_req & bus.bus_wr;
  assign sel      = bus.bus_addr[5:4];
  assign acc      = bus.bus_addr[3:2];
  assign wd       = bus.bus_wdata[N_SRC-1:0];
  assign claim_rd = rd & (sel == 2'd2);
  assign claim_wr = wr & (sel == 2'd2);

  assign rise   = sync2_q & ~edge_q;
  assign masked = pend_q & en_q;
  // Isolate lowest set bit: lowest index wins.
  assign win_oh = masked & (-masked);

  assign unused_bits = ^{bus.bus_addr[1:0],
                         bus.bus_wdata[31:N_SRC]};

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (masked[i]) win_id = ID_W'(i + 1);
  end

  always_comb begin
    status = '0;
    status[8] = (state_q == ACTIVE);
    status[ID_W-1:0] = cur_id_q;
  end

  always_comb begin
    en_d     = en_q;
    pend_d   = pend_q;
    state_d  = state_q;
    cur_id_d = cur_id_q;
    rdata_d  = rdata_q;

    if (wr && sel == 2'd0) begin
      unique case (acc)
        2'd0:    en_d = wd;
        2'd1:    en_d = en_q | wd;
        2'd2:    en_d = en_q & ~wd;
        default: en_d = en_q ^ wd;
      endcase
    end

    if (wr && sel == 2'd1) begin
      unique case (acc)
        2'd0:    pend_d = pend_q & wd;
        2'd1:    pend_d = pend_q;
        default: pend_d = pend_q & ~wd;
      endcase
    end

    if (claim_rd && state_q == IDLE && |masked) begin
      pend_d   = pend_d & ~win_oh;
      state_d  = ACTIVE;
      cur_id_d = win_id;
    end

    if (claim_wr && state_q == ACTIVE &&
        bus.bus_wdata[ID_W-1:0] == cur_id_q) begin
      state_d  = IDLE;
      cur_id_d = '0;
    end

    // New edges override any clear in the same cycle.
    pend_d = pend_d | rise;

    if (rd) begin
      unique case (sel)
        2'd0:    rdata_d = 32'(en_q);
        2'd1:    rdata_d = 32'(pend_q);
        2'd2:    rdata_d = (state_q == IDLE) ?
                           32'(win_id) : '0;
        default: rdata_d = status;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      edge_q   <= '0;
      en_q     <= '0;
      pend_q   <= '0;
      state_q  <= IDLE;
      cur_id_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= irq_src;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      en_q     <= en_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      rdata_q  <= rdata_d;
      ack_q    <= bus.bus_req;
      irq_q    <= (state_q == IDLE) && (|masked);
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_ack   = ack_q;
  assign irq_out       = irq_q;
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller.
// Reads queue expectations; observed ack/data are queued at completion.
module tb_irq_controller;
  localparam int N_SRC = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] irq_src;
  logic             irq_out;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  string       nm_q[$];

  irq_controller_if bus ();

  irq_controller #(
    .N_SRC(N_SRC),
    .ID_W (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_src(irq_src),
    .bus    (bus),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a,
                           input logic [31:0] d);
    bus.bus_req   = 1'b1;
    bus.bus_wr    = 1'b1;
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    tick(1);
    bus.bus_req   = 1'b0;
    bus.bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a,
                          input logic [31:0] e,
                          input string nm);
    exp_q.push_back({1'b1, e});
    nm_q.push_back(nm);
    bus.bus_req  = 1'b1;
    bus.bus_wr   = 1'b0;
    bus.bus_addr = a;
    tick(1);
    bus.bus_req  = 1'b0;
    obs_q.push_back({bus.bus_ack, bus.bus_rdata});
  endtask

  task automatic test_reset;
    logic [32:0] e, o;
    string n;
    rst = 1'b1;
    tick(2);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_irq: got %b want 0", irq_out);
    end
    checks++;
    if (bus.bus_ack !== 1'b0) begin
      failures++;
      $display("FAIL rst_ack: got %b want 0", bus.bus_ack);
    end
    checks++;
    if (bus.bus_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_rdata: got %h want 0",
               bus.bus_rdata);
    end
    rst = 1'b0;
    tick(1);
    bus_read(6'h00, 32'h0, "rst_enable");
    bus_read(6'h10, 32'h0, "rst_pending");
    bus_read(6'h30, 32'h0, "rst_status");
    bus_read(6'h20, 32'h0, "rst_claim");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_enable_alias;
    logic [32:0] e, o;
    string n;
    bus_write(6'h00, 32'h0000_00F0);
    bus_write(6'h04, 32'h0000_0001);
    bus_write(6'h08, 32'h0000_0010);
    bus_write(6'h0C, 32'h0000_0003);
    bus_read(6'h00, 32'h0000_00E2, "en_alias");
    bus_write(6'h00, 32'hFFFF_FFFF);
    bus_read(6'h00, 32'h0000_FFFF, "en_width");
    bus_write(6'h08, 32'hFFFF_FFFF);
    bus_read(6'h00, 32'h0, "en_clr_all");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_claim;
    logic [32:0] e, o;
    string n;
    bus_write(6'h00, 32'h0000_000C);
    irq_src[3] = 1'b1;
    tick(2);
    irq_src[3] = 1'b0;
    irq_src[2] = 1'b1;
    tick(2);
    bus_read(6'h10, 32'h08, "pend_pre_edge");
    bus_read(6'h10, 32'h0C, "pend_both");
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL irq_on: got %b want 1", irq_out);
    end
    bus_read(6'h20, 32'h3, "claim_id3");
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL irq_claim_cyc: got %b want 1",
               irq_out);
    end
    bus_read(6'h10, 32'h08, "pend_after_claim");
    bus_read(6'h30, 32'h103, "status_active");
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL irq_active: got %b want 0", irq_out);
    end
    bus_read(6'h20, 32'h0, "claim_in_active");
    irq_src[2] = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_complete;
    logic [32:0] e, o;
    string n;
    bus_write(6'h20, 32'h5);
    bus_read(6'h30, 32'h103, "status_bad_cmpl");
    bus_write(6'h20, 32'h3);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL irq_cmpl_edge: got %b want 0",
               irq_out);
    end
    tick(1);
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL irq_reassert: got %b want 1",
               irq_out);
    end
    bus_read(6'h20, 32'h4, "claim_id4");
    bus_read(6'h30, 32'h104, "status_id4");
    bus_write(6'h20, 32'h4);
    bus_read(6'h20, 32'h0, "claim_empty");
    bus_read(6'h30, 32'h0, "status_idle");
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL irq_empty: got %b want 0", irq_out);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_pending_alias;
    logic [32:0] e, o;
    string n;
    bus_write(6'h00, 32'h0);
    irq_src[3:0] = 4'hF;
    tick(2);
    irq_src[3:0] = 4'h0;
    tick(3);
    bus_read(6'h10, 32'h0F, "pend_f");
    bus_write(6'h14, 32'hFF);
    bus_read(6'h10, 32'h0F, "pend_set_noop");
    bus_write(6'h10, 32'h05);
    bus_read(6'h10, 32'h05, "pend_main");
    bus_write(6'h1C, 32'h04);
    bus_read(6'h10, 32'h01, "pend_inv");
    bus_write(6'h18, 32'h01);
    bus_read(6'h10, 32'h00, "pend_clr");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_level_hold;
    logic [32:0] e, o;
    string n;
    irq_src[1] = 1'b1;
    tick(20);
    bus_read(6'h10, 32'h02, "level_once");
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL irq_disabled: got %b want 0",
               irq_out);
    end
    bus_write(6'h18, 32'h02);
    bus_read(6'h10, 32'h00, "level_no_repend");
    irq_src[1] = 1'b0;
    tick(4);
    irq_src[1] = 1'b1;
    tick(2);
    bus_write(6'h18, 32'h02);
    bus_read(6'h10, 32'h02, "set_beats_clr");
    bus_write(6'h04, 32'h02);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL irq_en_edge: got %b want 0", irq_out);
    end
    tick(1);
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL irq_late_en: got %b want 1", irq_out);
    end
    irq_src[1] = 1'b0;
    tick(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e, o;
    string n;
    irq_src[1] = 1'b1;
    tick(2);
    bus_read(6'h20, 32'h2, "claim_on_edge");
    bus_read(6'h10, 32'h02, "pend_kept");
    bus_read(6'h30, 32'h102, "status_id2");
    bus_write(6'h20, 32'h2);
    bus_read(6'h20, 32'h2, "claim_b2b");
    bus_write(6'h20, 32'h2);
    bus_read(6'h10, 32'h0, "pend_drained");
    bus_read(6'h30, 32'h0, "status_b2b");
    irq_src[1] = 1'b0;
    tick(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_reset_active;
    logic [32:0] e, o;
    string n;
    bus_write(6'h00, 32'h40);
    irq_src[6:5] = 2'b11;
    tick(2);
    irq_src[6:5] = 2'b00;
    tick(3);
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL irq_src6: got %b want 1", irq_out);
    end
    bus_read(6'h10, 32'h60, "pend_60");
    bus_read(6'h20, 32'h7, "claim_id7");
    bus_read(6'h30, 32'h107, "status_id7");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
    bus.bus_req  = 1'b1;
    bus.bus_wr   = 1'b0;
    bus.bus_addr = 6'h30;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.bus_ack !== 1'b0) begin
      failures++;
      $display("FAIL arst_ack: got %b want 0", bus.bus_ack);
    end
    checks++;
    if (bus.bus_rdata !== 32'h0) begin
      failures++;
      $display("FAIL arst_rdata: got %h want 0",
               bus.bus_rdata);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL arst_irq: got %b want 0", irq_out);
    end
    #2;
    bus.bus_req = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (bus.bus_ack !== 1'b0) begin
        failures++;
        $display("FAIL post_rst_ack: got %b want 0",
                 bus.bus_ack);
      end
    end
    bus_read(6'h00, 32'h0, "arst_enable");
    bus_read(6'h10, 32'h0, "arst_pending");
    bus_read(6'h30, 32'h0, "arst_status");
    bus_read(6'h20, 32'h0, "arst_claim");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      o = 'x;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    irq_src       = '0;
    bus.bus_req   = 1'b0;
    bus.bus_wr    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    test_reset;
    test_enable_alias;
    test_claim;
    test_complete;
    test_pending_alias;
    test_level_hold;
    test_back_to_back;
    test_reset_active;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
